ed25519_in_loader: RTL and testbench

- Input-side stage of the scalar point-multiplication datapath: deserialises the 64-bit host stream into one 768-bit job (M scalar, X coordinate, Y coordinate; 256 b each).
- Hands the complete job to the multiplication core over a valid/ready handshake.
- Computes per-field zero flags on the fly so the core can short-circuit edge jobs (M, X or Y all-zero) to an all-zero 512-bit result.

---
 rtl/ed25519_pkg.sv | 30 +++
 rtl/ed25519_beat_cnt.sv | 30 +++
 rtl/ed25519_in_loader.sv | 123 ++++++++++++
 tb/tb_ed25519_in_loader.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/ed25519_pkg.sv
// Shared constants, state encoding and job bundle
// for the ed25519 point-multiplication datapath.
package ed25519_pkg;

  localparam int DW     = 64;
  localparam int FW     = 256;
  localparam int NFIELD = 3;
  localparam int JW     = NFIELD * FW;
  localparam int NBEAT  = JW / DW;
  localparam int FBEAT  = FW / DW;

  localparam logic [1:0] FLD_M = 2'd0;
  localparam logic [1:0] FLD_X = 2'd1;
  localparam logic [1:0] FLD_Y = 2'd2;

  typedef enum logic {
    S_LOAD,
    S_HOLD
  } ld_state_t;

  typedef struct packed {
    logic [FW-1:0] m;
    logic [FW-1:0] x;
    logic [FW-1:0] y;
    logic          m_zero;
    logic          x_zero;
    logic          y_zero;
  } job_t;

endpackage

// File: rtl/ed25519_beat_cnt.sv
// Beat counter with field-index decode; wraps after
// N accepted beats. Shared by loader and serialiser.
module ed25519_beat_cnt #(
  parameter int N   = 12,
  parameter int PER = 4,
  parameter int CW  = $clog2(N),
  parameter int IW  = (N / PER > 1) ? $clog2(N / PER) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  output logic [IW-1:0] idx,
  output logic          last
);

  logic [CW-1:0] cnt;

  assign last = (cnt == CW'(N - 1));
  assign idx  = IW'(cnt / CW'(PER));

  // advance on each accepted beat, wrap on the last one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= last ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ed25519_in_loader.sv
// Host-stream deserialiser: packs 12 beats into one
// {M,X,Y} job and flags all-zero fields on the fly.
module ed25519_in_loader
  import ed25519_pkg::*;
(
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_in_valid,
  output logic          o_in_ready,
  input  logic [DW-1:0] i_in_data,
  output logic          o_job_valid,
  input  logic          i_job_ready,
  output logic [FW-1:0] o_job_m,
  output logic [FW-1:0] o_job_x,
  output logic [FW-1:0] o_job_y,
  output logic          o_m_zero,
  output logic          o_x_zero,
  output logic          o_y_zero,
  output logic          o_zero_result
);

  ld_state_t         state;
  logic [JW-1:0]     shreg;
  logic [NFIELD-1:0] acc;
  logic [NFIELD-1:0] acc_nxt;
  logic [NFIELD-1:0] zflag;
  logic [1:0]        fld;
  logic              last;
  logic              accept;
  logic              beat_zero;
  job_t              job;

  assign accept    = i_in_valid & o_in_ready;
  assign beat_zero = (i_in_data == '0);

  ed25519_beat_cnt #(
    .N   (NBEAT),
    .PER (FBEAT)
  ) u_cnt (
    .clk  (i_clk),
    .rst  (i_rst),
    .inc  (accept),
    .idx  (fld),
    .last (last)
  );

  // fold the current beat into its field's zero flag
  always_comb begin
    acc_nxt = acc;
    for (int f = 0; f < NFIELD; f++) begin
      if (fld == 2'(f)) begin
        acc_nxt[f] = acc[f] & beat_zero;
      end
    end
  end

  // zero accumulators, re-armed once a job completes
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      acc <= '1;
    end else if (accept) begin
      acc <= last ? '1 : acc_nxt;
    end
  end

  // MSB-first shift; the held job is the register itself
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      shreg <= '0;
    end else if (accept) begin
      shreg <= {shreg[JW-DW-1:0], i_in_data};
    end
  end

  // load/hold handshake FSM with registered flags
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state         <= S_LOAD;
      o_in_ready    <= 1'b0;
      o_job_valid   <= 1'b0;
      zflag         <= '0;
      o_zero_result <= 1'b0;
    end else begin
      unique case (state)
        S_LOAD: begin
          o_in_ready <= 1'b1;
          if (accept && last) begin
            state         <= S_HOLD;
            o_in_ready    <= 1'b0;
            o_job_valid   <= 1'b1;
            zflag         <= acc_nxt;
            o_zero_result <= |acc_nxt;
          end
        end
        S_HOLD: begin
          if (i_job_ready) begin
            state         <= S_LOAD;
            o_in_ready    <= 1'b1;
            o_job_valid   <= 1'b0;
            zflag         <= '0;
            o_zero_result <= 1'b0;
          end
        end
        default: state <= S_LOAD;
      endcase
    end
  end

  assign job.m      = shreg[JW-1 -: FW];
  assign job.x      = shreg[JW-FW-1 -: FW];
  assign job.y      = shreg[FW-1:0];
  assign job.m_zero = zflag[FLD_M];
  assign job.x_zero = zflag[FLD_X];
  assign job.y_zero = zflag[FLD_Y];

  assign o_job_m  = job.m;
  assign o_job_x  = job.x;
  assign o_job_y  = job.y;
  assign o_m_zero = job.m_zero;
  assign o_x_zero = job.x_zero;
  assign o_y_zero = job.y_zero;

endmodule

// File: tb/tb_ed25519_in_loader.sv
// Self-checking bench for ed25519_in_loader: vector
// table, randomized jobs vs model, hold and reset cases.
module tb_ed25519_in_loader;
  import ed25519_pkg::*;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          job_valid;
  logic          job_ready = 1'b0;
  logic [FW-1:0] job_m, job_x, job_y;
  logic          m_zero, x_zero, y_zero;
  logic          zero_result;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ed25519_in_loader dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_in_valid    (in_valid),
    .o_in_ready    (in_ready),
    .i_in_data     (in_data),
    .o_job_valid   (job_valid),
    .i_job_ready   (job_ready),
    .o_job_m       (job_m),
    .o_job_x       (job_x),
    .o_job_y       (job_y),
    .o_m_zero      (m_zero),
    .o_x_zero      (x_zero),
    .o_y_zero      (y_zero),
    .o_zero_result (zero_result)
  );

  a_valid_hold: assert property (
    @(posedge clk) disable iff (rst)
    $fell(job_valid) |-> $past(job_ready)
  );

  typedef struct {
    logic [FW-1:0] m;
    logic [FW-1:0] x;
    logic [FW-1:0] y;
    bit            gaps;
    logic [3:0]    exp;
  } vec_t;

  vec_t vt[6];

  task automatic chk(input string nm,
                     input logic [FW-1:0] act,
                     input logic [FW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // reference: flag = field equals zero, result = any flag
  function automatic logic [3:0] model(
    input logic [FW-1:0] m, x, y);
    logic mz, xz, yz;
    mz = (m == '0);
    xz = (x == '0);
    yz = (y == '0);
    return {mz, xz, yz, mz | xz | yz};
  endfunction

  function automatic logic [FW-1:0] rnd256();
    logic [FW-1:0] r;
    int sel;
    for (int i = 0; i < FW / 32; i++)
      r[i*32 +: 32] = $urandom;
    sel = $urandom_range(0, 7);
    if (sel < 2) r = '0;
    else if (sel == 2) begin
      r = '0;
      r[$urandom_range(0, FW - 1)] = 1'b1;
    end
    return r;
  endfunction

  // drive nb beats of {m,x,y}; ends at the negedge after
  // the last accepting edge with in_valid dropped
  task automatic send_job(input logic [JW-1:0] job,
                          input int nb,
                          input bit gaps);
    int b = 0;
    int t = 0;
    bit ph = 1'b0;
    while (b < nb && t < 400) begin
      @(negedge clk);
      ph = gaps ? !ph : 1'b1;
      in_valid = ph;
      in_data  = job[JW-1-DW*b -: DW];
      if (in_valid && in_ready) b++;
      t++;
    end
    chk("beats_accepted", FW'(b), FW'(nb));
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic check_job(input string tag,
                           input logic [FW-1:0] m, x, y,
                           input logic [3:0] e);
    chk({tag, "_valid"}, FW'(job_valid), FW'(1));
    chk({tag, "_rdy"}, FW'(in_ready), FW'(0));
    chk({tag, "_m"}, job_m, m);
    chk({tag, "_x"}, job_x, x);
    chk({tag, "_y"}, job_y, y);
    chk({tag, "_mz"}, FW'(m_zero), FW'(e[3]));
    chk({tag, "_xz"}, FW'(x_zero), FW'(e[2]));
    chk({tag, "_yz"}, FW'(y_zero), FW'(e[1]));
    chk({tag, "_zr"}, FW'(zero_result), FW'(e[0]));
  endtask

  task automatic take_job(input string tag);
    job_ready = 1'b1;
    @(negedge clk);
    job_ready = 1'b0;
    chk({tag, "_tk_valid"}, FW'(job_valid), FW'(0));
    chk({tag, "_tk_rdy"}, FW'(in_ready), FW'(1));
    chk({tag, "_tk_zr"}, FW'(zero_result), FW'(0));
  endtask

  initial begin
    logic [FW-1:0] ypat;
    logic [FW-1:0] a, b, c;
    logic [3:0]    e;
    ypat = 256'h0e8f12a2_7c3d5e91_44a0b6f3_19d2e870_c5b3a1f4_6e08d927_3fa1c65b_2b2602b1;

    vt[0] = '{'0, '0, '0, 1'b0, 4'b1111};
    vt[1] = '{'1, '1, ypat, 1'b0, 4'b0000};
    vt[2] = '{'1, '1, '0, 1'b0, 4'b0011};
    vt[3] = '{'0, 256'h1, '0, 1'b0, 4'b1011};
    vt[4] = '{256'h1 << 255, '1, 256'h1 << 128,
              1'b1, 4'b0000};
    vt[5] = '{ypat, '0, '1, 1'b1, 4'b0101};

    #12;
    chk("rst_valid", FW'(job_valid), FW'(0));
    chk("rst_rdy", FW'(in_ready), FW'(0));
    chk("rst_zr", FW'(zero_result), FW'(0));
    chk("rst_mz", FW'(m_zero), FW'(0));
    chk("rst_m", job_m, '0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      send_job({vt[i].m, vt[i].x, vt[i].y},
               NBEAT, vt[i].gaps);
      check_job($sformatf("vec%0d", i),
                vt[i].m, vt[i].x, vt[i].y, vt[i].exp);
      take_job($sformatf("vec%0d", i));
    end

    for (int i = 0; i < 6; i++) begin
      a = rnd256();
      b = rnd256();
      c = rnd256();
      e = model(a, b, c);
      send_job({a, b, c}, NBEAT, 1'b0);
      check_job($sformatf("rnd%0d", i), a, b, c, e);
      take_job($sformatf("rnd%0d", i));
      send_job({a, b, c}, NBEAT, 1'b1);
      check_job($sformatf("gap%0d", i), a, b, c, e);
      take_job($sformatf("gap%0d", i));
    end

    send_job('0, NBEAT, 1'b0);
    for (int k = 0; k < 20; k++) begin
      chk("hold_rdy", FW'(in_ready), FW'(0));
      chk("hold_valid", FW'(job_valid), FW'(1));
      chk("hold_x", job_x, '0);
      chk("hold_mz", FW'(m_zero), FW'(1));
      in_valid = 1'b1;
      in_data  = {$urandom, $urandom};
      @(negedge clk);
    end
    in_valid = 1'b0;
    check_job("hold_end", '0, '0, '0, 4'b1111);
    take_job("hold_end");
    a = rnd256() | 256'h80;
    b = rnd256() | 256'h1;
    c = rnd256() | (256'h1 << 200);
    send_job({a, b, c}, NBEAT, 1'b0);
    check_job("rearm", a, b, c, 4'b0000);
    take_job("rearm");

    a = '1;
    send_job({a, a, a}, 8, 1'b0);
    rst = 1'b1;
    #1;
    chk("rst_mid_valid", FW'(job_valid), FW'(0));
    chk("rst_mid_rdy", FW'(in_ready), FW'(0));
    chk("rst_mid_m", job_m, '0);
    @(negedge clk);
    rst = 1'b0;
    a = rnd256();
    b = '0;
    c = rnd256() | 256'h4;
    send_job({a, b, c}, NBEAT, 1'b0);
    check_job("post_rst", a, b, c, model(a, b, c));

    rst = 1'b1;
    #1;
    chk("rst_hold_valid", FW'(job_valid), FW'(0));
    chk("rst_hold_zr", FW'(zero_result), FW'(0));
    chk("rst_hold_y", job_y, '0);
    @(negedge clk);
    rst = 1'b0;
    send_job({ypat, ypat, ypat}, NBEAT, 1'b1);
    check_job("post_rst2", ypat, ypat, ypat, 4'b0000);
    take_job("post_rst2");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
